// File: rtl/apb_spi_master_param.sv
// APB-programmable SPI master with TX/RX FIFOs, runtime frame length,
// clock divider, CPOL/CPHA, bit order and sticky status/interrupts.
module apb_spi_master_param_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         do_push;
    logic         do_pop;

    // Extra MSB on the pointers separates full from empty
    assign empty   = (wp == rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wp[AW-1:0]] <= din;
                wp <= wp + (AW+1)'(1);
            end
            if (do_pop) rp <= rp + (AW+1)'(1);
        end
    end
endmodule

module apb_spi_master_param #(
    parameter int APB_DWIDTH = 16,
    parameter int FRAME_MAX  = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_SS     = 8
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [6:0]            PADDR,
    input  logic [APB_DWIDTH-1:0] PWDATA,
    output logic [APB_DWIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  SPISCLKO,
    output logic                  SPISDO,
    input  logic                  SPISDI,
    output logic [NUM_SS-1:0]     SPISS,
    output logic                  SPIOEN,
    output logic                  SPIINT,
    output logic                  SPIRXAVAIL,
    output logic                  SPITXRFM
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [4:0] FLEN_SAT = 5'(FRAME_MAX - 1);

    logic [1:0]           state;
    logic                 en;
    logic                 cpol;
    logic                 cpha;
    logic                 lsb_first;
    logic [4:0]           flen_m1;
    logic [7:0]           clkdiv;
    logic [NUM_SS-1:0]    ssel;
    logic [2:0]           intmask;
    logic                 done_flag;
    logic                 rxovf;
    logic                 int_q;

    logic                 a_cpha;
    logic                 a_lsb;
    logic [4:0]           a_flen;
    logic [7:0]           a_div;
    logic [NUM_SS-1:0]    a_ssel;

    logic [FRAME_MAX-1:0] tx_sh;
    logic [FRAME_MAX-1:0] rx_sh;
    logic [FRAME_MAX-1:0] tx_nxt;
    logic [FRAME_MAX-1:0] rx_nxt;
    logic [FRAME_MAX-1:0] tx_head;
    logic [FRAME_MAX-1:0] rx_head;
    logic [7:0]           div_cnt;
    logic [5:0]           edge_cnt;
    logic                 sclk_q;
    logic                 sdo_q;

    logic                 tx_full;
    logic                 tx_empty;
    logic                 rx_full;
    logic                 rx_empty;
    logic [31:0]          wdata;
    logic [31:0]          rdata;
    logic                 addr_ok;
    logic                 access;
    logic                 wr;
    logic                 rd;
    logic                 tx_push;
    logic                 rx_pop;
    logic                 intclr;
    logic                 busy;
    logic                 tick;
    logic                 last_edge;
    logic                 sample_edge;
    logic                 first_bit;
    logic                 unused_ok;

    function automatic logic pick(input logic [FRAME_MAX-1:0] v,
                                  input logic lsb, input logic [4:0] fl);
        logic [FRAME_MAX-1:0] s;
        s = v >> fl;
        return lsb ? v[0] : s[0];
    endfunction

    assign PREADY    = 1'b1;
    assign wdata     = 32'(PWDATA);
    assign addr_ok   = (PADDR[1:0] == 2'b00) && (PADDR <= 7'h1C);
    assign access    = PSEL && PENABLE && PREADY;
    assign wr        = access && PWRITE && addr_ok;
    assign rd        = access && !PWRITE && addr_ok;
    assign tx_push   = wr && (PADDR == 7'h10);
    assign intclr    = wr && (PADDR == 7'h1C);
    assign rx_pop    = rd && (PADDR == 7'h14);
    assign busy      = (state != S_IDLE);
    assign unused_ok = ^{wdata, rdata};

    apb_spi_master_param_fifo #(.W(FRAME_MAX), .DEPTH(FIFO_DEPTH)) u_tx (
        .clk   (PCLK),
        .rst_n (PRESETN),
        .push  (tx_push),
        .din   (PWDATA[FRAME_MAX-1:0]),
        .pop   (state == S_LOAD),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    apb_spi_master_param_fifo #(.W(FRAME_MAX), .DEPTH(FIFO_DEPTH)) u_rx (
        .clk   (PCLK),
        .rst_n (PRESETN),
        .push  (state == S_DONE),
        .din   (rx_sh),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    always_comb begin
        rdata = '0;
        case (PADDR)
            7'h00:   rdata = {23'd0, flen_m1, lsb_first, cpha, cpol, en};
            7'h04:   rdata = {24'd0, clkdiv};
            7'h08:   rdata = 32'(ssel);
            7'h0C:   rdata = {25'd0, done_flag, rxovf, busy,
                              rx_empty, rx_full, tx_empty, tx_full};
            7'h14:   rdata = 32'(rx_head);
            7'h18:   rdata = {29'd0, intmask};
            default: rdata = '0;
        endcase
    end

    assign PRDATA  = (PRESETN && PSEL && addr_ok) ? rdata[APB_DWIDTH-1:0] : '0;
    assign PSLVERR = PRESETN && PSEL && PENABLE && !addr_ok;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            en        <= 1'b0;
            cpol      <= 1'b0;
            cpha      <= 1'b0;
            lsb_first <= 1'b0;
            flen_m1   <= '0;
            clkdiv    <= '0;
            ssel      <= '0;
            intmask   <= '0;
            done_flag <= 1'b0;
            rxovf     <= 1'b0;
            int_q     <= 1'b0;
        end else begin
            if (wr && PADDR == 7'h00) begin
                en        <= wdata[0];
                cpol      <= wdata[1];
                cpha      <= wdata[2];
                lsb_first <= wdata[3];
                flen_m1   <= (wdata[8:4] > FLEN_SAT) ? FLEN_SAT : wdata[8:4];
            end
            if (wr && PADDR == 7'h04) clkdiv  <= wdata[7:0];
            if (wr && PADDR == 7'h08) ssel    <= wdata[NUM_SS-1:0];
            if (wr && PADDR == 7'h18) intmask <= wdata[2:0];
            // A set in the same cycle as a clear wins
            done_flag <= (done_flag && !(intclr && wdata[0])) ||
                         (state == S_DONE);
            rxovf     <= (rxovf && !(intclr && wdata[1])) ||
                         (state == S_DONE && rx_full && !rx_pop);
            int_q     <= |(intmask & {tx_empty, rxovf, done_flag});
        end
    end

    assign tick        = (div_cnt == a_div);
    assign last_edge   = (edge_cnt == {a_flen, 1'b1});
    assign sample_edge = (edge_cnt[0] == a_cpha);
    assign tx_nxt      = a_lsb ? (tx_sh >> 1) : (tx_sh << 1);
    assign rx_nxt      = a_lsb ? ((rx_sh >> 1) | (FRAME_MAX'(SPISDI) << a_flen))
                               : {rx_sh[FRAME_MAX-2:0], SPISDI};
    assign first_bit   = pick(tx_head, lsb_first, flen_m1);

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state    <= S_IDLE;
            a_cpha   <= 1'b0;
            a_lsb    <= 1'b0;
            a_flen   <= '0;
            a_div    <= '0;
            a_ssel   <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            sclk_q   <= 1'b0;
            sdo_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (en && !tx_empty) state <= S_LOAD;
                end
                S_LOAD: begin
                    a_cpha   <= cpha;
                    a_lsb    <= lsb_first;
                    a_flen   <= flen_m1;
                    a_div    <= clkdiv;
                    a_ssel   <= ssel;
                    tx_sh    <= tx_head;
                    rx_sh    <= '0;
                    sdo_q    <= first_bit;
                    sclk_q   <= cpol;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (tick) begin
                        div_cnt  <= '0;
                        sclk_q   <= !sclk_q;
                        edge_cnt <= edge_cnt + 6'd1;
                        if (sample_edge) begin
                            rx_sh <= rx_nxt;
                        end else if (a_cpha) begin
                            sdo_q <= pick(tx_sh, a_lsb, a_flen);
                            tx_sh <= tx_nxt;
                        end else begin
                            sdo_q <= pick(tx_nxt, a_lsb, a_flen);
                            tx_sh <= tx_nxt;
                        end
                        if (last_edge) state <= S_DONE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    state <= (en && !tx_empty) ? S_LOAD : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign SPISCLKO   = (state == S_SHIFT) ? sclk_q : cpol;
    assign SPISDO     = (state == S_LOAD) ? first_bit :
                        (state == S_IDLE) ? 1'b0 : sdo_q;
    assign SPISS      = (state == S_IDLE) ? '1 :
                        (state == S_LOAD) ? ~ssel : ~a_ssel;
    assign SPIOEN     = (state == S_IDLE);
    assign SPIINT     = int_q;
    assign SPIRXAVAIL = !rx_empty;
    assign SPITXRFM   = !tx_full;
endmodule

// File: tb/tb_apb_spi_master_param.sv
// Randomized and directed bench for apb_spi_master_param with
// SDI looped back to SDO and a bit-order/frame model.
module tb_apb_spi_master_param;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel = 1'b0;
    logic        penable = 1'b0;
    logic        pwrite = 1'b0;
    logic [6:0]  paddr = '0;
    logic [15:0] pwdata = '0;
    logic [15:0] prdata;
    logic        pready;
    logic        pslverr;
    logic        sclk;
    logic        sdo;
    logic [7:0]  ss;
    logic        oen;
    logic        intr;
    logic        rxavail;
    logic        txrfm;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    apb_spi_master_param dut (
        .PCLK       (clk),
        .PRESETN    (rst_n),
        .PSEL       (psel),
        .PENABLE    (penable),
        .PWRITE     (pwrite),
        .PADDR      (paddr),
        .PWDATA     (pwdata),
        .PRDATA     (prdata),
        .PREADY     (pready),
        .PSLVERR    (pslverr),
        .SPISCLKO   (sclk),
        .SPISDO     (sdo),
        .SPISDI     (sdo),
        .SPISS      (ss),
        .SPIOEN     (oen),
        .SPIINT     (intr),
        .SPIRXAVAIL (rxavail),
        .SPITXRFM   (txrfm)
    );

    // Line monitor: SCLK edges, SS activity and SDO at sample edges
    int   cyc = 0;
    int   rises = 0;
    int   period = 0;
    int   last_rise = 0;
    int   ss_low = 0;
    int   ss_rise = 0;
    logic prev_sclk = 1'b0;
    logic prev_ss0 = 1'b1;
    bit   m_cpol = 0;
    bit   m_cpha = 0;
    bit   bits[$];

    always @(negedge clk) begin
        cyc++;
        if (ss[0] === 1'b0) ss_low++;
        if (ss[0] === 1'b1 && prev_ss0 === 1'b0) ss_rise++;
        if (oen === 1'b0 && sclk !== prev_sclk) begin
            if (sclk === 1'b1) begin
                rises++;
                period = cyc - last_rise;
                last_rise = cyc;
            end
            if ((sclk != m_cpol) == !m_cpha) bits.push_back(sdo);
        end
        prev_sclk = sclk;
        prev_ss0 = ss[0];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apb_wr(input logic [6:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [6:0] a, output logic [15:0] d,
                          output logic err);
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        d = prdata;
        err = pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic mon_clear(input bit cp, input bit ch);
        @(negedge clk);
        m_cpol = cp;
        m_cpha = ch;
        rises = 0;
        ss_low = 0;
        ss_rise = 0;
        bits.delete();
    endtask

    task automatic wait_idle();
        logic [15:0] st;
        logic        e;
        for (int i = 0; i < 400; i++) begin
            apb_rd(7'h0C, st, e);
            if (st[4] == 1'b0 && st[1] == 1'b1) return;
        end
        vectors++;
        miscompares++;
        $error("FAIL wait_idle: busy after 400 polls, status %0h", st);
    endtask

    // Bits in wire order, first transmitted in bit n-1 of the result
    function automatic logic [31:0] wire_order(input logic [31:0] w,
                                               input int n, input bit lsb);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[n-1-i] = lsb ? w[i] : w[n-1-i];
        return r;
    endfunction

    function automatic logic [31:0] got_bits();
        logic [31:0] r;
        r = '0;
        foreach (bits[i]) r = {r[30:0], bits[i]};
        return r;
    endfunction

    function automatic logic [31:0] fmask(input int n);
        return (n >= 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
    endfunction

    task automatic run_frame(input bit cp, input bit ch, input bit lsb,
                             input int fm1, input int div,
                             input logic [15:0] word, input string tag);
        logic [15:0] d;
        logic        e;
        int          n;
        n = fm1 + 1;
        apb_wr(7'h04, 16'(div));
        apb_wr(7'h00, 16'({fm1[4:0], lsb, ch, cp, 1'b1}));
        mon_clear(cp, ch);
        apb_wr(7'h10, word);
        wait_idle();
        check({tag, "_nbits"}, 32'(bits.size()), 32'(n));
        check({tag, "_order"}, got_bits(), wire_order(32'(word), n, lsb));
        apb_rd(7'h14, d, e);
        check({tag, "_rx"}, 32'(d), 32'(word) & fmask(n));
    endtask

    logic [15:0] d;
    logic        e;
    logic [15:0] w[5];
    bit          cp;
    bit          ch;
    bit          lb;
    int          fm;

    initial begin
        rst_n = 1'b0;
        #22;
        check("rst_ss", 32'(ss), 32'hFF);
        check("rst_sclk", 32'(sclk), 0);
        check("rst_sdo", 32'(sdo), 0);
        check("rst_oen", 32'(oen), 1);
        check("rst_int", 32'(intr), 0);
        check("rst_rxavail", 32'(rxavail), 0);
        check("rst_txrfm", 32'(txrfm), 1);
        check("rst_prdata", 32'(prdata), 0);
        check("rst_pslverr", 32'(pslverr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        apb_rd(7'h0C, d, e);
        check("status_after_reset", 32'(d), 32'h0A);

        // Basic mode 0 frame, 8 bits, divider 1
        apb_wr(7'h08, 16'h0001);
        apb_wr(7'h04, 16'h0001);
        apb_wr(7'h00, 16'h0071);
        mon_clear(0, 0);
        apb_wr(7'h10, 16'h00A5);
        wait_idle();
        check("m0_rises", 32'(rises), 8);
        check("m0_period", 32'(period), 4);
        check("m0_ss_low", 32'(ss_low), 34);
        check("m0_order", got_bits(), 32'hA5);
        apb_rd(7'h14, d, e);
        check("m0_rx", 32'(d), 32'h00A5);
        apb_rd(7'h0C, d, e);
        check("m0_done", 32'(d[6]), 1);
        apb_wr(7'h1C, 16'h0001);
        apb_rd(7'h0C, d, e);
        check("done_clr", 32'(d[6]), 0);

        // Mode 3, LSB first, 12-bit frame
        apb_wr(7'h00, 16'h00BE);
        @(negedge clk);
        check("m3_idle_high_pre", 32'(sclk), 1);
        run_frame(1, 1, 1, 11, 1, 16'h00F3, "m3");
        check("m3_bits_const", got_bits(), 32'hCF0);
        @(negedge clk);
        check("m3_idle_high_post", 32'(sclk), 1);

        // Random mode/length/divider/data frames
        for (int i = 0; i < 8; i++) begin
            cp = 1'($urandom);
            ch = 1'($urandom);
            lb = 1'($urandom);
            fm = int'($urandom_range(3, 15));
            run_frame(cp, ch, lb, fm, int'($urandom_range(0, 2)),
                      16'($urandom), $sformatf("rnd%0d", i));
        end

        // FLEN_M1 saturates at FRAME_MAX-1
        apb_wr(7'h00, 16'h01F0);
        apb_rd(7'h00, d, e);
        check("flen_sat", 32'(d), 32'h00F0);

        // Fill TX with EN=0, fifth word dropped
        apb_wr(7'h04, 16'h0001);
        apb_wr(7'h18, 16'h0002);
        apb_wr(7'h00, 16'h0070);
        for (int i = 0; i < 5; i++) begin
            w[i] = 16'($urandom_range(0, 255));
            apb_wr(7'h10, w[i]);
        end
        apb_rd(7'h0C, d, e);
        check("txfull", 32'(d[0]), 1);
        @(negedge clk);
        check("txrfm_full", 32'(txrfm), 0);
        mon_clear(0, 0);
        apb_wr(7'h00, 16'h0071);
        wait_idle();
        check("b2b_rises", 32'(rises), 32);
        check("b2b_ss_rise", 32'(ss_rise), 1);
        check("b2b_ss_low", 32'(ss_low), 136);
        apb_rd(7'h0C, d, e);
        check("rxfull", 32'(d[2]), 1);
        check("int_before_ovf", 32'(intr), 0);

        // One more frame overflows the RX FIFO
        apb_wr(7'h10, 16'h005A);
        wait_idle();
        apb_rd(7'h0C, d, e);
        check("rxovf_set", 32'(d[5]), 1);
        check("int_ovf", 32'(intr), 1);
        apb_wr(7'h1C, 16'h0002);
        apb_rd(7'h0C, d, e);
        check("rxovf_clr", 32'(d[5]), 0);
        @(negedge clk);
        check("int_clr", 32'(intr), 0);
        for (int i = 0; i < 4; i++) begin
            apb_rd(7'h14, d, e);
            check($sformatf("b2b_rx%0d", i), 32'(d), 32'(w[i]));
        end

        // Address decode errors and empty RX read
        apb_rd(7'h20, d, e);
        check("err20_slverr", 32'(e), 1);
        check("err20_prdata", 32'(d), 0);
        apb_rd(7'h1E, d, e);
        check("err1e_slverr", 32'(e), 1);
        check("err1e_prdata", 32'(d), 0);
        apb_wr(7'h06, 16'h0033);
        apb_rd(7'h04, d, e);
        check("bad_wr_noeffect", 32'(d), 32'h0001);
        apb_rd(7'h14, d, e);
        check("rx_empty_read", 32'(d), 0);
        check("rx_empty_slverr", 32'(e), 0);
        check("rxavail_empty", 32'(rxavail), 0);
        run_frame(0, 1, 0, 7, 0, 16'($urandom), "after_empty");

        // Reset in the middle of a frame
        apb_wr(7'h04, 16'h0003);
        apb_wr(7'h00, 16'h0073);
        apb_wr(7'h10, 16'h00C3);
        repeat (20) @(negedge clk);
        check("mid_oen", 32'(oen), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_ss", 32'(ss), 32'hFF);
        check("mid_rst_sclk", 32'(sclk), 0);
        check("mid_rst_oen", 32'(oen), 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        apb_rd(7'h0C, d, e);
        check("mid_rst_status", 32'(d), 32'h0A);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/apb_spi_master_param.md
APB_SPI_MASTER_PARAM -- requirements
Module: apb_spi_master_param

Interface
REQ-001 SHALL have parameter APB_DWIDTH, default 16, the APB data width (8, 16 or 32).
REQ-002 SHALL have parameter FRAME_MAX, default 16, the maximum frame bits (4..32, no greater than APB_DWIDTH).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, the TX and RX FIFO entries (power of 2, at least 2).
REQ-004 SHALL have parameter NUM_SS, default 8, the slave-select count (1..16).
REQ-005 SHALL have ports:
- PCLK  in  1  sole clock, all logic on its rising edge.
- PRESETN  in  1  asynchronous active-low reset.
- PSEL, PENABLE, PWRITE  in  1 each  APB control.
- PADDR  in  7  byte address.
- PWDATA  in  APB_DWIDTH  write data.
- PRDATA  out  APB_DWIDTH  read data.
- PREADY  out  1  constant 1.
- PSLVERR  out  1  error on an unmapped address.
- SPISCLKO  out  1  serial clock.
- SPISDO  out  1  serial data out.
- SPISDI  in  1  serial data in.
- SPISS  out  NUM_SS  active-low selects.
- SPIOEN  out  1  active-low SDO output enable.
- SPIINT  out  1  interrupt.
- SPIRXAVAIL  out  1  RX FIFO not empty.
- SPITXRFM  out  1  TX FIFO not full.

Function
REQ-006 SHALL provide the following register map (byte offset):
- 0x00 CTRL (rw): [0] EN, [1] CPOL, [2] CPHA, [3] LSB_FIRST, [8:4] FLEN_M1.
- 0x04 CLKDIV (rw, 8 bits).
- 0x08 SSEL (rw, NUM_SS bits).
- 0x0C STATUS (ro): [0] TXFULL, [1] TXEMPTY, [2] RXFULL, [3] RXEMPTY, [4] BUSY, [5] RXOVF, [6] DONE.
- 0x10 TXDATA (wo).
- 0x14 RXDATA (ro, pops).
- 0x18 INTMASK (rw): [0] DONE, [1] RXOVF, [2] TXEMPTY.
- 0x1C INTCLR (w1c): [0] DONE, [1] RXOVF.
REQ-007 SHALL assert PSLVERR, with PRDATA 0, during the access phase for any offset above 0x1C or not word-aligned; such a write SHALL have no effect.
REQ-008 SHALL act on writes and RXDATA pops only when PSEL, PENABLE and PREADY are all high, so each pops or pushes exactly once per access.
REQ-009 SHALL saturate FLEN_M1 writes at FRAME_MAX-1, giving a frame length of FLEN_M1+1 bits.
REQ-010 SHALL drop a TXDATA write when the TX FIFO is full, leaving the FIFO unchanged.
REQ-011 SHALL return 0 on an RXDATA read when the RX FIFO is empty.
REQ-012 SHALL have the FSM states IDLE, LOAD, SHIFT and DONE.
REQ-013 SHALL leave IDLE for LOAD when EN is 1 and TXEMPTY is 0.
REQ-014 SHALL, in LOAD (1 cycle), pop TX into the shift register and assert SPISS wherever SSEL is 1.
REQ-015 SHALL, in SHIFT, toggle SPISCLKO every CLKDIV+1 PCLK cycles, producing 2*(FLEN_M1+1) edges.
REQ-016 SHALL, with CPHA=0, present the first bit on SPISDO in LOAD, sample on leading edges and shift on trailing edges.
REQ-017 SHALL, with CPHA=1, shift on leading edges and sample on trailing edges.
REQ-018 SHALL hold SPISCLKO at CPOL whenever the FSM is not in SHIFT.
REQ-019 SHALL shift MSB-first unless LSB_FIRST is 1; received data SHALL be right-justified with upper bits 0.
REQ-020 SHALL, in DONE (1 cycle), push the received frame to RX, or set RXOVF and discard the frame if RX is full.
REQ-021 SHALL, in DONE, set sticky DONE.
REQ-022 SHALL leave DONE for LOAD if EN is 1 and TX is not empty, with SPISS held low and no gap.
REQ-023 SHALL otherwise leave DONE for IDLE, deasserting SPISS.
REQ-024 SHALL, when EN is cleared mid-SHIFT, finish the current frame, then return to IDLE.
REQ-025 SHALL apply writes to CPOL, CPHA, LSB_FIRST, FLEN_M1 and CLKDIV from the next LOAD onwards, not mid-frame.
REQ-026 SHALL drive BUSY=1 in any state other than IDLE.
REQ-027 SHALL drive SPIOEN=0 in LOAD, SHIFT and DONE, and 1 otherwise.
REQ-028 SHALL register SPIINT as |(INTMASK & {TXEMPTY, RXOVF, DONE}).
REQ-029 SHALL, on a simultaneous DONE-set and INTCLR[0] write, leave DONE set.
REQ-030 SHALL apply a simultaneous FIFO push and pop on a full FIFO, leaving the count unchanged.
REQ-031 SHALL wrap the FIFO pointers modulo FIFO_DEPTH and use an extra occupancy bit to distinguish full from empty.

Reset
REQ-032 SHALL, on PRESETN low, asynchronously clear all registers, empty both FIFOs and force the FSM to IDLE.
REQ-033 SHALL drive these values during reset: SPISS all 1, SPISCLKO 0, SPISDO 0, SPIOEN 1, SPIINT 0, SPIRXAVAIL 0, SPITXRFM 1, PRDATA 0, PSLVERR 0.
REQ-034 SHALL, on reset asserted mid-frame, return SPISS high immediately with no frame pushed to RX.

Verification
REQ-035 SHALL cover: with CTRL=0x0071 (EN, FLEN 8), CLKDIV=1, SSEL=0x01, TX 0xA5 and SDI looped to SDO -> SPISS[0] low for the frame, 8 SCLK periods of 4 PCLK each, RXDATA=0x00A5, DONE=1.
REQ-036 SHALL cover: CPOL=1, CPHA=1, LSB_FIRST=1, FLEN 12, TX 0x0F3 -> SDO bit order 1,1,0,0,1,1,1,1,0,0,0,0; SCLK idle high.
REQ-037 SHALL cover: FIFO_DEPTH=4, EN=0, five TXDATA writes -> TXFULL=1, SPITXRFM=0, fifth word dropped; then EN=1 -> 4 back-to-back frames with SPISS low throughout.
REQ-038 SHALL cover: RX FIFO full (4 frames unread) plus one more frame -> RXOVF=1, SPIINT=1 when INTMASK=0x2; INTCLR=0x2 -> RXOVF=0.
REQ-039 SHALL cover: reads of 0x20 and 0x1E -> PSLVERR=1, PRDATA=0; RXDATA read when empty -> 0 with RX pointers unchanged.
REQ-040 SHALL cover: PRESETN pulsed low mid-SHIFT -> SPISS=all 1, SPISCLKO=0 and SPIOEN=1 in the same cycle, with STATUS=0x0A (TXEMPTY, RXEMPTY) after release.
